// File: rtl/puf_challenge_gen.sv
// PUF challenge generator: LFSR challenge re-issued repeat_cfg times per value,
// offered on a valid/ready handshake with a one-deep request queue.
module puf_challenge_gen #(
  parameter int unsigned       CHAL_W    = 128,
  parameter logic [CHAL_W-1:0] INIT_SEED = CHAL_W'(128'h0C9F99D6_C9F99D6C_9F99D6C9_F99D6C9F),
  parameter logic [CHAL_W-1:0] TAPS      = CHAL_W'(128'h80000001_00000000_80000000_00000001),
  parameter int unsigned       REP_W     = 6,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              seed_load,
  input  logic [CHAL_W-1:0] seed_in,
  input  logic [REP_W-1:0]  repeat_cfg,
  output logic              challenge_valid,
  input  logic              challenge_ready,
  output logic [CHAL_W-1:0] challenge,
  output logic [REP_W-1:0]  rep_idx,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic              req_drop,
  output logic              lockup_err
);

  localparam int unsigned REP_W1 = REP_W + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_n;
  logic              req_q;
  logic              pend;
  logic              pend_n;
  logic              valid_n;
  logic [CHAL_W-1:0] seed_n;
  logic [REP_W-1:0]  rep_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              drop_n;
  logic              lock_n;
  logic              req_edge;
  logic              hs;
  logic [REP_W-1:0]  eff_rep;
  logic [REP_W:0]    rep_inc;

  // Shift right with tap parity fed back into the MSB.
  function automatic logic [CHAL_W-1:0] lfsr_step(input logic [CHAL_W-1:0] s);
    return {^(s & TAPS), s[CHAL_W-1:1]};
  endfunction

  always_comb begin
    state_n  = state;
    pend_n   = pend;
    seed_n   = challenge;
    rep_n    = rep_idx;
    cnt_n    = issue_cnt;
    drop_n   = 1'b0;
    lock_n   = lockup_err;
    req_edge = request & ~req_q;
    hs       = challenge_valid & challenge_ready;
    eff_rep  = (repeat_cfg == '0) ? REP_W'(1) : repeat_cfg;
    rep_inc  = {1'b0, rep_idx} + REP_W1'(1);

    case (state)
      IDLE: begin
        // A zero seed would lock the LFSR, so it is replaced and flagged.
        if (seed_load) begin
          rep_n = '0;
          if (seed_in == '0) begin
            seed_n = INIT_SEED;
            lock_n = 1'b1;
          end else begin
            seed_n = seed_in;
          end
        end
        if (req_edge | pend) begin
          state_n = OFFER;
          pend_n  = 1'b0;
        end
      end
      OFFER: begin
        if (hs) begin
          cnt_n = issue_cnt + CNT_W'(1);
          if (rep_inc >= {1'b0, eff_rep}) begin
            seed_n = lfsr_step(challenge);
            rep_n  = '0;
          end else begin
            rep_n = rep_inc[REP_W-1:0];
          end
          // Queued request drives the next offer; a coincident edge takes its slot.
          state_n = (pend | req_edge) ? OFFER : IDLE;
          pend_n  = pend & req_edge;
        end else if (req_edge) begin
          if (pend) begin
            drop_n = 1'b1;
          end else begin
            pend_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        pend_n  = 1'b0;
      end
    endcase

    valid_n = (state_n == OFFER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      req_q           <= 1'b0;
      pend            <= 1'b0;
      challenge_valid <= 1'b0;
      challenge       <= INIT_SEED;
      rep_idx         <= '0;
      issue_cnt       <= '0;
      req_drop        <= 1'b0;
      lockup_err      <= 1'b0;
    end else begin
      state           <= state_n;
      req_q           <= request;
      pend            <= pend_n;
      challenge_valid <= valid_n;
      challenge       <= seed_n;
      rep_idx         <= rep_n;
      issue_cnt       <= cnt_n;
      req_drop        <= drop_n;
      lockup_err      <= lock_n;
    end
  end

endmodule

// File: tb/tb_puf_challenge_gen.sv
// Scoreboard bench for puf_challenge_gen: expected challenge/rep_idx pairs are
// queued per request and popped at each handshake.
module tb_puf_challenge_gen;

  localparam int unsigned CHAL_W = 128;
  localparam int unsigned REP_W  = 6;
  localparam int unsigned CNT_W  = 32;
  localparam logic [CHAL_W-1:0] INIT = 128'h0C9F99D6_C9F99D6C_9F99D6C9_F99D6C9F;
  localparam logic [CHAL_W-1:0] TAPV = 128'h80000001_00000000_80000000_00000001;

  logic              clk = 1'b0;
  logic              rst;
  logic              request;
  logic              seed_load;
  logic [CHAL_W-1:0] seed_in;
  logic [REP_W-1:0]  repeat_cfg;
  logic              challenge_valid;
  logic              challenge_ready;
  logic [CHAL_W-1:0] challenge;
  logic [REP_W-1:0]  rep_idx;
  logic [CNT_W-1:0]  issue_cnt;
  logic              req_drop;
  logic              lockup_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CHAL_W+REP_W-1:0] exp_q[$];
  logic [CHAL_W-1:0]       mdl_seed;
  logic [REP_W-1:0]        mdl_rep;

  puf_challenge_gen dut (
    .clk(clk), .rst(rst), .request(request), .seed_load(seed_load),
    .seed_in(seed_in), .repeat_cfg(repeat_cfg), .challenge_valid(challenge_valid),
    .challenge_ready(challenge_ready), .challenge(challenge), .rep_idx(rep_idx),
    .issue_cnt(issue_cnt), .req_drop(req_drop), .lockup_err(lockup_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [CHAL_W-1:0] ref_step(input logic [CHAL_W-1:0] s);
    return {^(s & TAPV), s[CHAL_W-1:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    int eff;
    exp_q.push_back({mdl_seed, mdl_rep});
    eff = (repeat_cfg == '0) ? 1 : int'(repeat_cfg);
    if (int'(mdl_rep) + 1 >= eff) begin
      mdl_seed = ref_step(mdl_seed);
      mdl_rep  = '0;
    end else begin
      mdl_rep = mdl_rep + REP_W'(1);
    end
  endtask

  task automatic pulse();
    request = 1'b1;
    tick();
    request = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    mdl_seed = INIT;
    mdl_rep  = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !challenge_valid) break;
      tick();
    end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  // Handshake happens at the next rising edge when valid & ready hold here.
  always @(negedge clk) begin
    logic [CHAL_W+REP_W-1:0] e;
    if (!rst && challenge_valid && challenge_ready) begin
      if (exp_q.size() == 0) begin
        check("hs_unexpected", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        check("hs_chal", challenge, e[CHAL_W+REP_W-1:REP_W]);
        check("hs_rep", 128'(rep_idx), 128'(e[REP_W-1:0]));
      end
    end
  end

  initial begin
    rst = 1'b1; request = 1'b0; seed_load = 1'b0; seed_in = '0;
    repeat_cfg = 6'd2; challenge_ready = 1'b0;
    tick();
    do_reset();
    check("rst_valid", 128'(challenge_valid), 128'd0);
    check("rst_chal", challenge, INIT);
    check("rst_cnt", 128'(issue_cnt), 128'd0);
    check("rst_rep", 128'(rep_idx), 128'd0);
    check("rst_drop", 128'(req_drop), 128'd0);
    check("rst_lock", 128'(lockup_err), 128'd0);

    // Three requests, always ready, repeat 2.
    challenge_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp();
      pulse();
    end
    wait_drain();
    check("t1_cnt", 128'(issue_cnt), 128'd3);
    check("t1_chal", challenge, 128'h064FCCEB64FCCEB64FCCEB64FCCEB64F);
    check("t1_rep", 128'(rep_idx), 128'd1);

    // Held offer, ready at edge k+5.
    do_reset();
    challenge_ready = 1'b0;
    push_exp();
    request = 1'b1;
    tick();
    check("t2_valid0", 128'(challenge_valid), 128'd1);
    check("t2_chal0", challenge, INIT);
    request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold_valid", 128'(challenge_valid), 128'd1);
      check("t2_hold_chal", challenge, INIT);
    end
    challenge_ready = 1'b1;
    tick();
    challenge_ready = 1'b0;
    check("t2_valid_end", 128'(challenge_valid), 128'd0);
    check("t2_cnt", 128'(issue_cnt), 128'd1);
    check("t2_nostep", challenge, INIT);
    check("t2_rep", 128'(rep_idx), 128'd1);

    // Queue one request, drop two.
    push_exp();
    pulse();
    push_exp();
    request = 1'b1;
    tick();
    check("t3_queue_nodrop", 128'(req_drop), 128'd0);
    request = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      request = 1'b1;
      tick();
      check("t3_drop", 128'(req_drop), 128'd1);
      request = 1'b0;
      tick();
      check("t3_drop_clr", 128'(req_drop), 128'd0);
    end
    challenge_ready = 1'b1;
    tick();
    check("t3_valid_kept", 128'(challenge_valid), 128'd1);
    tick();
    challenge_ready = 1'b0;
    check("t3_idle", 128'(challenge_valid), 128'd0);
    check("t3_cnt", 128'(issue_cnt), 128'd3);

    // Seed 1, repeat 0 behaves as 1.
    repeat_cfg = '0;
    seed_load = 1'b1; seed_in = 128'h1;
    tick();
    seed_load = 1'b0;
    mdl_seed = 128'h1; mdl_rep = '0;
    check("t4_load", challenge, 128'h1);
    challenge_ready = 1'b1;
    push_exp();
    pulse();
    tick();
    challenge_ready = 1'b0;
    check("t4_step", challenge, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    check("t4_rep", 128'(rep_idx), 128'd0);

    // Zero seed fallback, load ignored during offer.
    seed_load = 1'b1; seed_in = '0;
    tick();
    seed_load = 1'b0;
    mdl_seed = INIT; mdl_rep = '0;
    check("t5_lock", 128'(lockup_err), 128'd1);
    check("t5_chal", challenge, INIT);
    push_exp();
    pulse();
    seed_load = 1'b1; seed_in = 128'hDEAD;
    tick();
    seed_load = 1'b0;
    check("t5_offer_load", challenge, INIT);
    check("t5_offer_valid", 128'(challenge_valid), 128'd1);
    challenge_ready = 1'b1;
    tick();
    challenge_ready = 1'b0;
    check("t5_stepped", challenge, mdl_seed);
    seed_load = 1'b1; seed_in = 128'h5;
    tick();
    seed_load = 1'b0;
    mdl_seed = 128'h5; mdl_rep = '0;
    check("t5_sticky", 128'(lockup_err), 128'd1);
    check("t5_load5", challenge, 128'h5);

    // Lowering repeat below rep_idx+1 forces a step.
    repeat_cfg = 6'd3;
    challenge_ready = 1'b1;
    push_exp(); pulse();
    push_exp(); pulse();
    tick();
    check("t7_rep2", 128'(rep_idx), 128'd2);
    repeat_cfg = 6'd2;
    push_exp(); pulse();
    tick();
    challenge_ready = 1'b0;
    check("t7_rep0", 128'(rep_idx), 128'd0);
    check("t7_step", challenge, 128'h80000000_00000000_00000000_00000002);
    check("t7_cnt", 128'(issue_cnt), 128'd8);
    wait_drain();

    // Reset abandons an offer.
    request = 1'b1;
    tick();
    request = 1'b0;
    check("t6_offer", 128'(challenge_valid), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", 128'(challenge_valid), 128'd0);
    check("t6_chal", challenge, INIT);
    check("t6_cnt", 128'(issue_cnt), 128'd0);
    check("t6_lock", 128'(lockup_err), 128'd0);
    check("t6_rep", 128'(rep_idx), 128'd0);
    tick();
    check("t6_stay_idle", 128'(challenge_valid), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
